alu32: RTL and testbench

ALU32 -- requirements
Module: alu32

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 49 ++++
 rtl/alu32.sv | 41 ++++
 tb/tb_alu32.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select codes and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        F_AND  = 3'b000,
        F_OR   = 3'b001,
        F_ADD  = 3'b010,
        F_RSVD = 3'b011,
        F_ANDN = 3'b100,
        F_ORN  = 3'b101,
        F_SUB  = 3'b110,
        F_SLT  = 3'b111
    } alu_func_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder, with F[2] selecting the inverted B operand and carry-in.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       F,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             v;
    alu_func_e        func;

    assign func = alu_func_e'(F);
    assign bx   = F[2] ? ~B : B;
    assign sum  = A + bx + WIDTH'(F[2]);
    assign v    = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (func)
            F_AND:  result = A & bx;
            F_OR:   result = A | bx;
            F_ADD:  begin
                result = sum;
                ovf    = v;
            end
            F_ANDN: result = A & bx;
            F_ORN:  result = A | bx;
            F_SUB:  begin
                result = sum;
                ovf    = v;
            end
            // Sign of the difference, corrected when the subtraction overflowed.
            F_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v};
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu32.sv
// Registered ALU: one operation accepted per cycle, results on Y/Z/Ovf one cycle later.
module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       F,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             Ovf
);

    logic [WIDTH-1:0] result;
    logic             ovf_c;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .A      (A),
        .B      (B),
        .F      (F),
        .result (result),
        .ovf    (ovf_c)
    );

    // Zero flag is derived from the same next-state value as Y so both update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y   <= '0;
            Z   <= 1'b1;
            Ovf <= 1'b0;
        end else begin
            Y   <= result;
            Z   <= (result == '0);
            Ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Bench for alu32: directed corner vectors plus random operations against an arithmetic reference.
module tb_alu32;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  F;
    logic [31:0] Y;
    logic        Z;
    logic        Ovf;

    int n_chk;
    int n_fail;

    alu32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .F     (F),
        .Y     (Y),
        .Z     (Z),
        .Ovf   (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference computed with signed 64-bit arithmetic rather than the adder/overflow formula.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  output logic [31:0] y, output logic ovf);
        longint sa;
        longint sb;
        longint r;
        longint max_s;
        longint min_s;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        max_s = 64'sd2147483647;
        min_s = -64'sd2147483648;
        ovf   = 1'b0;
        y     = 32'h0;
        case (f)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: begin
                r   = sa + sb;
                y   = r[31:0];
                ovf = (r > max_s) || (r < min_s);
            end
            3'd3: y = 32'h0;
            3'd4: y = a & ~b;
            3'd5: y = a | ~b;
            3'd6: begin
                r   = sa - sb;
                y   = r[31:0];
                ovf = (r > max_s) || (r < min_s);
            end
            default: y = (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Drive one operation on the falling edge, check it just after the next rising edge.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [31:0] ey;
        logic        eo;
        @(negedge clk);
        A = a;
        B = b;
        F = f;
        model(a, b, f, ey, eo);
        @(posedge clk);
        #1;
        chk({tag, ".Y"}, Y, ey);
        chk({tag, ".Z"}, {31'b0, Z}, {31'b0, (ey == 32'h0)});
        chk({tag, ".Ovf"}, {31'b0, Ovf}, {31'b0, eo});
    endtask

    initial begin
        logic [31:0] corner [6];
        logic [31:0] ra;
        logic [31:0] rb;
        n_chk  = 0;
        n_fail = 0;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h8000_0000;
        corner[5] = 32'h8000_0001;

        rst_n = 1'b0;
        A = $urandom;
        B = $urandom;
        F = 3'b010;
        #12;
        chk("rst.Y", Y, 32'h0);
        chk("rst.Z", {31'b0, Z}, 32'd1);
        chk("rst.Ovf", {31'b0, Ovf}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk.Y", Y, 32'h0);
        chk("rst_clk.Z", {31'b0, Z}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        step("first_add", 32'h0000_00FF, 32'h1, 3'b010);
        chk("first_add.Y_lit", Y, 32'h0000_0100);

        step("add_wrap", 32'h1, 32'hFFFF_FFFF, 3'b010);
        step("add_ovf", 32'h7FFF_FFFF, 32'h1, 3'b010);
        chk("add_ovf.lit", {31'b0, Ovf}, 32'd1);
        step("sub0", 32'h0, 32'hFFFF_FFFF, 3'b110);
        step("sub1", 32'h1, 32'h1, 3'b110);
        step("sub2", 32'h100, 32'h1, 3'b110);
        chk("sub2.lit", Y, 32'hFF);
        step("sub_ovf", 32'h8000_0000, 32'h1, 3'b110);
        step("slt0", 32'h0, 32'h1, 3'b111);
        step("slt1", 32'h0, 32'hFFFF_FFFF, 3'b111);
        step("slt2", 32'hFFFF_FFFF, 32'h0, 3'b111);
        step("slt3", 32'h1, 32'h0, 3'b111);
        step("slt4", 32'h8000_0000, 32'h1, 3'b111);
        chk("slt4.lit", Y, 32'h1);
        step("and0", 32'hFFFF_FFFF, 32'h1234_5678, 3'b000);
        step("and1", 32'h1234_5678, 32'h8765_4321, 3'b000);
        chk("and1.lit", Y, 32'h0224_4220);
        step("or0", 32'h1234_5678, 32'h8765_4321, 3'b001);
        chk("or0.lit", Y, 32'h9775_5779);
        step("andn", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
        step("orn0", 32'h0, 32'hFFFF_FFFF, 3'b101);
        step("orn1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101);
        step("rsvd", 32'h7FFF_FFFF, 32'h1, 3'b011);

        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 8; j++) begin
                ra = corner[i % 6];
                rb = corner[(i / 6) % 6];
                step("corner", ra, rb, 3'(j));
            end
        end

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            step("rand", ra, rb, 3'($urandom_range(0, 7)));
        end

        // Mid-stream reset between clock edges must clear outputs without a clock.
        step("pre_rst", 32'h7FFF_FFFF, 32'h1, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.Y", Y, 32'h0);
        chk("mid_rst.Z", {31'b0, Z}, 32'd1);
        chk("mid_rst.Ovf", {31'b0, Ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.Y", Y, 32'h0);
        step("post_rst", 32'h0000_00FF, 32'h1, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
